// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: issues PC-ordered requests on a request/grant
// memory port, pairs in-order responses with their PCs and hands {instr, pc}
// to decode. Redirects discard buffered and in-flight wrong-path fetches.
`timescale 1ns/1ps
module fetch_ctrl #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            branch_en_i,
  input  logic [XLEN-1:0] branch_target_i,
  input  logic            stall_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  output logic            instr_valid_o,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] instr_pc_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] LP_DEPTH = (CW+1)'(DEPTH);

  // Control state
  logic [XLEN-1:0] r_pc;
  logic [CW-1:0]   r_in_flight;
  logic [CW-1:0]   r_drop_cnt;
  logic [CW-1:0]   r_buf_cnt;
  logic [AW-1:0]   r_buf_rd;
  logic [AW-1:0]   r_buf_wr;
  logic [AW-1:0]   r_pcq_rd;
  logic [AW-1:0]   r_pcq_wr;

  // Data storage (no reset; validity is tracked by the control state)
  logic [31:0]     r_buf_instr [DEPTH];
  logic [XLEN-1:0] r_buf_pc    [DEPTH];
  logic [XLEN-1:0] r_pcq       [DEPTH];

  logic [CW:0]     w_occ;
  logic            w_req;
  logic            w_issue;
  logic            w_rv;
  logic            w_drop;
  logic            w_push;
  logic            w_valid;
  logic            w_pop;
  logic [XLEN-1:0] w_target;

  // Request, response and handoff qualification
  always_comb begin
    w_occ    = {1'b0, r_in_flight} + {1'b0, r_buf_cnt};
    w_req    = !reset_i && !branch_en_i && (w_occ < LP_DEPTH);
    w_issue  = w_req && imem_gnt_i;
    // A response with nothing outstanding is a protocol violation and is ignored.
    w_rv     = imem_rvalid_i && (r_in_flight != '0);
    // Responses owed to an earlier redirect, or arriving in a redirect cycle, are wrong-path.
    w_drop   = w_rv && ((r_drop_cnt != '0) || branch_en_i);
    w_push   = w_rv && !w_drop;
    w_valid  = (r_buf_cnt != '0) && !branch_en_i && !reset_i;
    w_pop    = w_valid && !stall_i;
    // Redirect targets are forced to word alignment.
    w_target = branch_target_i & ~XLEN'(3);
  end

  assign imem_req_o    = w_req;
  assign imem_addr_o   = r_pc;
  assign instr_valid_o = w_valid;
  assign instr_o       = r_buf_instr[r_buf_rd];
  assign instr_pc_o    = r_buf_pc[r_buf_rd];

  // Control state update: PC, credit counters, queue pointers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_pc        <= RESET_PC;
      r_in_flight <= '0;
      r_drop_cnt  <= '0;
      r_buf_cnt   <= '0;
      r_buf_rd    <= '0;
      r_buf_wr    <= '0;
      r_pcq_rd    <= '0;
      r_pcq_wr    <= '0;
    end else if (branch_en_i) begin
      // Everything still outstanding after this cycle belongs to the old path.
      r_pc        <= w_target;
      r_in_flight <= r_in_flight - CW'(w_rv);
      r_drop_cnt  <= r_in_flight - CW'(w_rv);
      r_buf_cnt   <= '0;
      r_buf_rd    <= '0;
      r_buf_wr    <= '0;
      r_pcq_rd    <= '0;
      r_pcq_wr    <= '0;
    end else begin
      if (w_issue) begin
        r_pc     <= r_pc + XLEN'(4);
        r_pcq_wr <= r_pcq_wr + AW'(1);
      end
      r_in_flight <= r_in_flight + CW'(w_issue) - CW'(w_rv);
      if (w_drop) begin
        r_drop_cnt <= r_drop_cnt - CW'(1);
      end
      // Dropped responses had their PCs discarded at the redirect, so only kept ones pop.
      if (w_push) begin
        r_pcq_rd <= r_pcq_rd + AW'(1);
        r_buf_wr <= r_buf_wr + AW'(1);
      end
      if (w_pop) begin
        r_buf_rd <= r_buf_rd + AW'(1);
      end
      r_buf_cnt <= r_buf_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  // Data capture: PC of each granted request and each kept response
  always_ff @(posedge clk_i) begin
    if (w_issue) begin
      r_pcq[r_pcq_wr] <= r_pc;
    end
    if (w_push && !reset_i) begin
      r_buf_instr[r_buf_wr] <= imem_rdata_i;
      r_buf_pc[r_buf_wr]    <= r_pcq[r_pcq_rd];
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
`timescale 1ns/1ps
module tb_fetch_ctrl;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT (RESET_PC = 0)
  logic        reset_i, branch_en_i, stall_i, imem_gnt_i, imem_rvalid_i;
  logic [31:0] branch_target_i, imem_rdata_i;
  logic        imem_req_o, instr_valid_o;
  logic [31:0] imem_addr_o, instr_o, instr_pc_o;

  fetch_ctrl #(.XLEN(32), .RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .reset_i(reset_i), .branch_en_i(branch_en_i),
    .branch_target_i(branch_target_i), .stall_i(stall_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .instr_valid_o(instr_valid_o), .instr_o(instr_o), .instr_pc_o(instr_pc_o)
  );

  // Second DUT for the PC wrap case
  logic        w_reset, w_br, w_stall, w_gnt, w_rv;
  logic [31:0] w_tgt, w_rdata;
  logic        w_req, w_vld;
  logic [31:0] w_addr, w_instr, w_pc;

  fetch_ctrl #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut_wrap (
    .clk_i(clk), .reset_i(w_reset), .branch_en_i(w_br),
    .branch_target_i(w_tgt), .stall_i(w_stall),
    .imem_req_o(w_req), .imem_addr_o(w_addr), .imem_gnt_i(w_gnt),
    .imem_rvalid_i(w_rv), .imem_rdata_i(w_rdata),
    .instr_valid_o(w_vld), .instr_o(w_instr), .instr_pc_o(w_pc)
  );

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'hC0DE_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Directed vector table
  typedef struct {
    logic        rst, br;
    logic [31:0] tgt;
    logic        stall, gnt, rv;
    logic [31:0] rdpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_pc;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic rst, input logic br, input logic [31:0] tgt,
                     input logic stall, input logic gnt, input logic rv,
                     input logic [31:0] rdpc, input logic e_req,
                     input logic [31:0] e_addr, input logic e_vld,
                     input logic [31:0] e_pc);
    vec_t v;
    v.rst = rst; v.br = br; v.tgt = tgt; v.stall = stall; v.gnt = gnt;
    v.rv = rv; v.rdpc = rdpc; v.e_req = e_req; v.e_addr = e_addr;
    v.e_vld = e_vld; v.e_pc = e_pc;
    vecs.push_back(v);
  endtask

  // Random-phase memory and reference model
  typedef struct { logic [31:0] addr; int rdy; } mreq_t;
  typedef struct { logic [31:0] pc; bit wrong; } ob_t;
  mreq_t       memq[$];
  ob_t         outs[$];
  logic [31:0] bufq[$];
  logic [31:0] mpc;

  initial begin
    #300000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] wq[$];
    logic [31:0] grants[$];
    logic [31:0] exp_dpc;
    logic        r, b, s, g, rv, e_req, e_vld;
    logic [31:0] t;
    ob_t         o;

    reset_i = 1'b1; branch_en_i = 1'b0; branch_target_i = '0; stall_i = 1'b0;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
    w_reset = 1'b1; w_br = 1'b0; w_tgt = '0; w_stall = 1'b0; w_gnt = 1'b1;
    w_rv = 1'b0; w_rdata = '0;

    //   rst br tgt          st gnt rv rdpc          req addr          vld pc
    add(1, 0, 32'h0,       0, 0, 0, 32'h0,       0, 32'h0,       0, 32'h0);
    add(0, 0, 32'h0,       0, 1, 0, 32'h0,       1, 32'h0,       0, 32'h0);
    add(0, 0, 32'h0,       0, 1, 1, 32'h0,       1, 32'h4,       0, 32'h0);
    add(0, 0, 32'h0,       0, 1, 1, 32'h4,       0, 32'h8,       1, 32'h0);
    add(0, 0, 32'h0,       0, 1, 0, 32'h0,       1, 32'h8,       1, 32'h4);
    add(0, 0, 32'h0,       0, 1, 1, 32'h8,       1, 32'hC,       0, 32'h0);
    add(0, 0, 32'h0,       1, 1, 1, 32'hC,       0, 32'h10,      1, 32'h8);
    for (int i = 0; i < 4; i++)
      add(0, 0, 32'h0,     1, 1, 0, 32'h0,       0, 32'h10,      1, 32'h8);
    add(0, 0, 32'h0,       0, 1, 0, 32'h0,       0, 32'h10,      1, 32'h8);
    add(0, 0, 32'h0,       0, 1, 0, 32'h0,       1, 32'h10,      1, 32'hC);
    add(0, 0, 32'h0,       0, 1, 1, 32'h10,      1, 32'h14,      0, 32'h0);
    add(0, 1, 32'h100,     0, 1, 0, 32'h0,       0, 32'h18,      0, 32'h0);
    add(0, 0, 32'h0,       0, 1, 1, 32'h14,      1, 32'h100,     0, 32'h0);
    add(0, 0, 32'h0,       0, 0, 1, 32'h100,     1, 32'h104,     0, 32'h0);
    add(0, 1, 32'h203,     0, 1, 0, 32'h0,       0, 32'h104,     0, 32'h0);
    add(0, 0, 32'h0,       0, 1, 0, 32'h0,       1, 32'h200,     0, 32'h0);
    add(0, 1, 32'h300,     0, 1, 1, 32'h200,     0, 32'h204,     0, 32'h0);
    add(0, 0, 32'h0,       0, 1, 0, 32'h0,       1, 32'h300,     0, 32'h0);
    add(0, 0, 32'h0,       0, 0, 1, 32'h300,     1, 32'h304,     0, 32'h0);
    add(0, 0, 32'h0,       0, 0, 0, 32'h0,       1, 32'h304,     1, 32'h300);
    add(1, 0, 32'h0,       0, 1, 0, 32'h0,       0, 32'h0,       0, 32'h0);
    add(0, 0, 32'h0,       0, 0, 0, 32'h0,       1, 32'h0,       0, 32'h0);
    add(0, 0, 32'h0,       0, 0, 1, 32'h40,      1, 32'h0,       0, 32'h0);
    add(0, 0, 32'h0,       0, 0, 0, 32'h0,       1, 32'h0,       0, 32'h0);

    foreach (vecs[i]) begin
      @(negedge clk);
      reset_i = vecs[i].rst; branch_en_i = vecs[i].br; branch_target_i = vecs[i].tgt;
      stall_i = vecs[i].stall; imem_gnt_i = vecs[i].gnt; imem_rvalid_i = vecs[i].rv;
      imem_rdata_i = instr_of(vecs[i].rdpc);
      #1;
      chk($sformatf("vec%0d_req", i), {31'b0, imem_req_o}, {31'b0, vecs[i].e_req});
      chk($sformatf("vec%0d_vld", i), {31'b0, instr_valid_o}, {31'b0, vecs[i].e_vld});
      if (!vecs[i].rst)
        chk($sformatf("vec%0d_addr", i), imem_addr_o, vecs[i].e_addr);
      if (vecs[i].e_vld) begin
        chk($sformatf("vec%0d_pc", i), instr_pc_o, vecs[i].e_pc);
        chk($sformatf("vec%0d_instr", i), instr_o, instr_of(vecs[i].e_pc));
      end
    end

    // PC wrap: fetches FFFF_FFF8, FFFF_FFFC, 0000_0000
    @(negedge clk);
    w_reset = 1'b0;
    exp_dpc = 32'hFFFF_FFF8;
    for (int c = 0; c < 8; c++) begin
      w_rv    = (wq.size() > 0);
      w_rdata = w_rv ? instr_of(wq[0]) : 32'h0;
      #1;
      if (w_req) grants.push_back(w_addr);
      if (w_vld) begin
        chk("wrap_pc", w_pc, exp_dpc);
        chk("wrap_instr", w_instr, instr_of(exp_dpc));
        exp_dpc = exp_dpc + 32'h4;
      end
      if (w_rv) void'(wq.pop_front());
      if (w_req) wq.push_back(w_addr);
      @(negedge clk);
    end
    chk("wrap_grant_count", {31'b0, grants.size() >= 3}, 32'h1);
    if (grants.size() >= 3) begin
      chk("wrap_addr0", grants[0], 32'hFFFF_FFF8);
      chk("wrap_addr1", grants[1], 32'hFFFF_FFFC);
      chk("wrap_addr2", grants[2], 32'h0000_0000);
    end
    w_reset = 1'b1;

    // Randomized traffic against the queue-based reference model
    mpc = 32'h0;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      r  = (c == 0) || (c == 400);
      b  = !r && ($urandom_range(0, 9) == 0);
      t  = $urandom & 32'h0000_FFFF;
      s  = ($urandom_range(0, 3) == 0);
      g  = ($urandom_range(0, 2) != 0);
      rv = !r && (memq.size() > 0) && (memq[0].rdy <= c);
      reset_i = r; branch_en_i = b; branch_target_i = t; stall_i = s;
      imem_gnt_i = g; imem_rvalid_i = rv;
      imem_rdata_i = rv ? instr_of(memq[0].addr) : $urandom;
      #1;
      if (r) begin
        e_req = 1'b0; e_vld = 1'b0;
      end else begin
        e_req = !b && ((outs.size() + bufq.size()) < DEPTH);
        e_vld = (bufq.size() > 0) && !b;
      end
      chk("rnd_req", {31'b0, imem_req_o}, {31'b0, e_req});
      chk("rnd_vld", {31'b0, instr_valid_o}, {31'b0, e_vld});
      if (!r) begin
        chk("rnd_addr", imem_addr_o, mpc);
        chk("rnd_occupancy", {31'b0, (memq.size() + bufq.size()) <= DEPTH}, 32'h1);
      end
      if (e_vld) begin
        chk("rnd_pc", instr_pc_o, bufq[0]);
        chk("rnd_instr", instr_o, instr_of(bufq[0]));
      end
      // memory reacts to what the DUT actually did
      if (r) memq.delete();
      else begin
        if (rv) void'(memq.pop_front());
        if (imem_req_o && g) memq.push_back('{imem_addr_o, c + 1 + int'($urandom_range(0, 3))});
      end
      // reference model
      if (r) begin
        outs.delete(); bufq.delete(); mpc = 32'h0;
      end else begin
        if (b) begin
          bufq.delete();
          foreach (outs[k]) outs[k].wrong = 1'b1;
        end
        if (e_vld && !s) void'(bufq.pop_front());
        if (rv && outs.size() > 0) begin
          o = outs.pop_front();
          if (!o.wrong) bufq.push_back(o.pc);
        end
        if (e_req && g) begin
          outs.push_back('{mpc, 1'b0});
          mpc = mpc + 32'h4;
        end
        if (b) mpc = {t[31:2], 2'b00};
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
